control_unit: RTL and testbench

Instruction decoder for the 16-bit RISC pipeline, sitting in the decode stage between the fetch/IR latch and the ID/EX register. It maps the 5-bit opcode in `inst[15:11]` to a 7-bit control vector for memory access, stack-pointer and special-path control. The vector is available combinationally on `out` for same-cycle use in decode, and as a registered copy `out_q` for the execute stage.

---
 rtl/cu_pkg.sv | 49 ++++
 rtl/control_unit_decode.sv | 42 ++++
 rtl/control_unit.sv | 44 ++++
 tb/tb_control_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the decode-stage control unit: opcode encodings,
// control-bit positions and the control-vector type.
package cu_pkg;

  typedef logic [6:0] ctl_vec_t;
  typedef logic [4:0] opcode_t;

  localparam int MEM_RD  = 0;
  localparam int MEM_WR  = 1;
  localparam int SP_DEC  = 2;
  localparam int SP_INC  = 3;
  localparam int LD_EA   = 4;
  localparam int ST_EA   = 5;
  localparam int IMM_CTL = 6;

  localparam opcode_t OP_ADD   = 5'b00000;
  localparam opcode_t OP_SETC  = 5'b00001;
  localparam opcode_t OP_INC   = 5'b00010;
  localparam opcode_t OP_CLRC  = 5'b00011;
  localparam opcode_t OP_OUT   = 5'b00100;
  localparam opcode_t OP_MOV   = 5'b00101;
  localparam opcode_t OP_IN    = 5'b00110;
  localparam opcode_t OP_LDM   = 5'b00111;
  localparam opcode_t OP_INT   = 5'b01000;
  localparam opcode_t OP_CALL  = 5'b01001;
  localparam opcode_t OP_U0A   = 5'b01010;
  localparam opcode_t OP_U0B   = 5'b01011;
  localparam opcode_t OP_PUSH  = 5'b01100;
  localparam opcode_t OP_POP   = 5'b01101;
  localparam opcode_t OP_STD   = 5'b01110;
  localparam opcode_t OP_LDD   = 5'b01111;
  localparam opcode_t OP_DEC   = 5'b10000;
  localparam opcode_t OP_SUB   = 5'b10001;
  localparam opcode_t OP_OR    = 5'b10010;
  localparam opcode_t OP_AND   = 5'b10011;
  localparam opcode_t OP_SHL   = 5'b10100;
  localparam opcode_t OP_SHR   = 5'b10101;
  localparam opcode_t OP_NOT   = 5'b10110;
  localparam opcode_t OP_U17   = 5'b10111;
  localparam opcode_t OP_JZ    = 5'b11000;
  localparam opcode_t OP_JNZ   = 5'b11001;
  localparam opcode_t OP_JC    = 5'b11010;
  localparam opcode_t OP_JMP   = 5'b11011;
  localparam opcode_t OP_RET   = 5'b11100;
  localparam opcode_t OP_RTI   = 5'b11101;
  localparam opcode_t OP_RESET = 5'b11110;
  localparam opcode_t OP_NOP   = 5'b11111;

endpackage

// File: rtl/control_unit_decode.sv
// Purely combinational opcode -> control-vector mapping; anything not listed
// as a memory, stack or special-path opcode decodes to all zeros.
module control_unit_decode
  import cu_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [6:0] ctl
);

  always_comb begin
    ctl = '0;
    case (opcode)
      OP_PUSH: begin
        ctl[MEM_WR] = 1'b1;
        ctl[SP_DEC] = 1'b1;
      end
      OP_POP: begin
        ctl[MEM_RD] = 1'b1;
        ctl[SP_INC] = 1'b1;
      end
      OP_STD: begin
        ctl[MEM_WR] = 1'b1;
        ctl[ST_EA]  = 1'b1;
      end
      OP_LDD: begin
        ctl[MEM_RD] = 1'b1;
        ctl[LD_EA]  = 1'b1;
      end
      OP_SETC, OP_CLRC, OP_LDM, OP_SHL, OP_SHR, OP_RET, OP_RTI, OP_NOP: begin
        ctl[IMM_CTL] = 1'b1;
      end
      // ALU, I/O, branch and unassigned codes need none of these paths.
      OP_ADD, OP_INC, OP_OUT, OP_MOV, OP_IN, OP_INT, OP_CALL, OP_U0A, OP_U0B,
      OP_DEC, OP_SUB, OP_OR, OP_AND, OP_NOT, OP_U17,
      OP_JZ, OP_JNZ, OP_JC, OP_JMP, OP_RESET: begin
        ctl = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Decode-stage control unit: combinational control vector for decode plus a
// stall/flush-aware registered copy for the execute stage.
module control_unit
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst,
  input  logic        en,
  input  logic        flush,
  output logic [6:0]  out,
  output logic [6:0]  out_q
);

  ctl_vec_t out_d;
  logic     unused_operand_bits;

  // Operand fields never influence control decode.
  assign unused_operand_bits = ^inst[10:0];

  control_unit_decode u_decode (
    .opcode (inst[15:11]),
    .ctl    (out)
  );

  // Flush takes priority over a stall so a bubble can be inserted while held.
  always_comb begin
    out_d = out_q;
    if (flush) begin
      out_d = '0;
    end else if (en) begin
      out_d = out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: full opcode sweep plus register
// enable/flush/reset behaviour against hand-computed vectors.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [15:0] inst;
  logic        en;
  logic        flush;
  logic [6:0]  out;
  logic [6:0]  out_q;

  int n_checks;
  int n_errors;

  logic [6:0] exp_tbl [32];

  control_unit dut (
    .clk   (clk),
    .rst   (rst),
    .inst  (inst),
    .en    (en),
    .flush (flush),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    exp_tbl[0]  = 7'b0000000; exp_tbl[1]  = 7'b1000000;
    exp_tbl[2]  = 7'b0000000; exp_tbl[3]  = 7'b1000000;
    exp_tbl[4]  = 7'b0000000; exp_tbl[5]  = 7'b0000000;
    exp_tbl[6]  = 7'b0000000; exp_tbl[7]  = 7'b1000000;
    exp_tbl[8]  = 7'b0000000; exp_tbl[9]  = 7'b0000000;
    exp_tbl[10] = 7'b0000000; exp_tbl[11] = 7'b0000000;
    exp_tbl[12] = 7'b0000110; exp_tbl[13] = 7'b0001001;
    exp_tbl[14] = 7'b0100010; exp_tbl[15] = 7'b0010001;
    exp_tbl[16] = 7'b0000000; exp_tbl[17] = 7'b0000000;
    exp_tbl[18] = 7'b0000000; exp_tbl[19] = 7'b0000000;
    exp_tbl[20] = 7'b1000000; exp_tbl[21] = 7'b1000000;
    exp_tbl[22] = 7'b0000000; exp_tbl[23] = 7'b0000000;
    exp_tbl[24] = 7'b0000000; exp_tbl[25] = 7'b0000000;
    exp_tbl[26] = 7'b0000000; exp_tbl[27] = 7'b0000000;
    exp_tbl[28] = 7'b1000000; exp_tbl[29] = 7'b1000000;
    exp_tbl[30] = 7'b0000000; exp_tbl[31] = 7'b1000000;

    // Reset with a non-zero decode and enable high: reset must win.
    rst = 1'b1; en = 1'b1; flush = 1'b0; inst = 16'h3800;
    #1;
    check_eq("rst_out_ldm", out, 7'b1000000);
    tick();
    check_eq("rst_out_q", out_q, 7'b0000000);
    check_eq("rst_out_ldm_after", out, 7'b1000000);
    rst = 1'b0; en = 1'b0;

    // Opcode sweep with operand bits all zero, then all one.
    for (int pass = 0; pass < 2; pass++) begin
      for (int op = 0; op < 32; op++) begin
        inst = {op[4:0], (pass == 0) ? 11'h000 : 11'h7FF};
        #1;
        check_eq($sformatf("sweep_op%02d_p%0d", op, pass), out, exp_tbl[op]);
      end
    end
    check_eq("sweep_held_q", out_q, 7'b0000000);

    inst = 16'hB800; #1;
    check_eq("unassigned_10111", out, 7'b0000000);

    // Enabled capture of pop.
    inst = 16'h6800; en = 1'b1;
    tick();
    check_eq("pop_q", out_q, 7'b0001001);

    // Capture std then stall for 3 cycles with add on the input.
    inst = 16'h7000;
    tick();
    check_eq("std_q", out_q, 7'b0100010);
    en = 1'b0; inst = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_q_%0d", i), out_q, 7'b0100010);
    end
    check_eq("stall_out_add", out, 7'b0000000);

    // Flush with enable: bubble.
    flush = 1'b1; en = 1'b1; inst = 16'h6000;
    tick();
    check_eq("flush_en_q", out_q, 7'b0000000);
    flush = 1'b0;
    tick();
    check_eq("push_q", out_q, 7'b0000110);

    // Flush while stalled still clears.
    flush = 1'b1; en = 1'b0;
    tick();
    check_eq("flush_stall_q", out_q, 7'b0000000);
    flush = 1'b0;

    // Mid-stream reset.
    en = 1'b1; inst = 16'h7800;
    tick();
    check_eq("ldd_q", out_q, 7'b0010001);
    rst = 1'b1;
    tick();
    check_eq("midrst_q", out_q, 7'b0000000);
    check_eq("midrst_out", out, 7'b0010001);
    rst = 1'b0;

    // One-cycle lag across a short stream.
    inst = 16'h0800;
    tick();
    check_eq("lag_setc_q", out_q, 7'b1000000);
    inst = 16'h6FFF;
    #1;
    check_eq("lag_pop_out", out, 7'b0001001);
    check_eq("lag_prev_q", out_q, 7'b1000000);
    tick();
    check_eq("lag_pop_q", out_q, 7'b0001001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
